// File: rtl/ps2_kbd_pkg.sv
// Shared types and Set-2 scan constants for the PS/2 keyboard controller.
package ps2_kbd_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } state_t;

    // Key identity: scan code plus its E0 extension flag.
    typedef struct packed {
        logic              ext;
        logic [BYTE_W-1:0] code;
    } key_id_t;

    localparam logic [BYTE_W-1:0] SC_EXT  = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK  = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_BAT  = 8'hAA;
    localparam logic [BYTE_W-1:0] SC_ACK  = 8'hFA;
    localparam logic [BYTE_W-1:0] SC_RSND = 8'hFE;
    localparam logic [BYTE_W-1:0] SC_ERR0 = 8'h00;
    localparam logic [BYTE_W-1:0] SC_ERR1 = 8'hFF;

    // Bytes from the keyboard that never describe a key.
    function automatic logic is_nonkey(input logic [BYTE_W-1:0] b);
        return (b == SC_ERR0) || (b == SC_BAT) || (b == SC_ACK) ||
               (b == SC_RSND) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Loadable down-counter that flags when a pending scan-code prefix has aged out.
module ps2_prefix_timer #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic clrn,
    input  logic load,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt;

    // Counts down from TIMEOUT-1 so expiry lands TIMEOUT cycles after the load.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign expire_c = run && (cnt == '0);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO, parses E0/F0 prefixes into make/break events
// and tracks the most recently held key, a press counter and a sticky error.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_overflow,
    output logic              nextdata_n,
    output logic [BYTE_W-1:0] key_code,
    output logic              key_ext,
    output logic              key_held,
    output logic              evt_make,
    output logic              evt_break,
    output logic [CNT_W-1:0]  press_cnt,
    output logic              err
);

    state_t            state, state_d;
    logic [BYTE_W-1:0] byte_r, byte_d;
    logic              ext_p, ext_d;
    logic              brk_p, brk_d;
    logic              nextdata_d;
    logic [BYTE_W-1:0] code_d;
    logic              kext_d;
    logic              held_d;
    logic              make_d;
    logic              break_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              err_d;
    logic              tmr_load;
    logic              tmr_expire_c;
    key_id_t           rx_id;
    key_id_t           held_id;
    logic              same_key_c;

    assign rx_id      = key_id_t'({ext_p, byte_r});
    assign held_id    = key_id_t'({key_ext, key_code});
    assign same_key_c = key_held && (rx_id == held_id);

    ps2_prefix_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_prefix_timer (
        .clk      (clk),
        .clrn     (clrn),
        .load     (tmr_load),
        .run      (ext_p | brk_p),
        .expire_c (tmr_expire_c)
    );

    // Next-state, handshake and decode logic.
    always_comb begin
        state_d    = state;
        byte_d     = byte_r;
        nextdata_d = 1'b1;
        ext_d      = ext_p;
        brk_d      = brk_p;
        code_d     = key_code;
        kext_d     = key_ext;
        held_d     = key_held;
        make_d     = 1'b0;
        break_d    = 1'b0;
        cnt_d      = press_cnt;
        err_d      = err | rx_overflow;
        tmr_load   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_ready) begin
                    byte_d     = rx_data;
                    state_d    = POP;
                    nextdata_d = 1'b0;
                end
            end
            POP: begin
                state_d = IDLE;
                if (byte_r == SC_EXT) begin
                    ext_d    = 1'b1;
                    tmr_load = 1'b1;
                end else if (byte_r == SC_BRK) begin
                    brk_d    = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (!is_nonkey(byte_r)) begin
                        if (brk_p) begin
                            break_d = 1'b1;
                            if (same_key_c) begin
                                held_d = 1'b0;
                            end
                        end else if (!same_key_c) begin
                            code_d = byte_r;
                            kext_d = ext_p;
                            held_d = 1'b1;
                            make_d = 1'b1;
                            cnt_d  = press_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte being decoded this cycle outranks the prefix timeout.
        if (tmr_expire_c && (state != POP)) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            byte_r     <= '0;
            ext_p      <= 1'b0;
            brk_p      <= 1'b0;
            nextdata_n <= 1'b1;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_held   <= 1'b0;
            evt_make   <= 1'b0;
            evt_break  <= 1'b0;
            press_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            byte_r     <= byte_d;
            ext_p      <= ext_d;
            brk_p      <= brk_d;
            nextdata_n <= nextdata_d;
            key_code   <= code_d;
            key_ext    <= kext_d;
            key_held   <= held_d;
            evt_make   <= make_d;
            evt_break  <= break_d;
            press_cnt  <= cnt_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: FIFO-style byte source, scan-code
// event model and directed plus randomized scenarios.
module tb_ps2_kbd_ctrl;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned TB_TIMEOUT = 64;

    logic             clk;
    logic             clrn;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             rx_overflow;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_held;
    logic             evt_make;
    logic             evt_break;
    logic [CNT_W-1:0] press_cnt;
    logic             err;

    ps2_kbd_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .nextdata_n  (nextdata_n),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_held    (key_held),
        .evt_make    (evt_make),
        .evt_break   (evt_break),
        .press_cnt   (press_cnt),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Receiver FIFO contents and observed behaviour.
    logic [7:0] fifo [$];
    int obs_make, obs_break, obs_low, proto_viol, both_evt;
    logic prev_low;

    // Reference model state: key tracking from the scan-code rules.
    logic [7:0]       m_code;
    logic             m_ext;
    logic             m_held;
    logic             m_ext_p;
    logic             m_brk_p;
    logic [CNT_W-1:0] m_cnt;
    int               m_make, m_break;

    function automatic logic nonkey(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic model_clear();
        m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0;
        m_ext_p = 1'b0; m_brk_p = 1'b0; m_cnt = '0;
        m_make = 0; m_break = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext_p = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_p = 1'b1;
        end else if (nonkey(b)) begin
            m_ext_p = 1'b0; m_brk_p = 1'b0;
        end else begin
            if (m_brk_p) begin
                m_break++;
                if (m_held && m_code == b && m_ext == m_ext_p) m_held = 1'b0;
            end else if (!(m_held && m_code == b && m_ext == m_ext_p)) begin
                m_code = b; m_ext = m_ext_p; m_held = 1'b1;
                m_make++; m_cnt = m_cnt + 1'b1;
            end
            m_ext_p = 1'b0; m_brk_p = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        rx_ready = 1'b1;
        rx_data  = fifo[0];
    endtask

    // One clock: pop the FIFO head if the DUT strobed, then sample outputs.
    task automatic step();
        logic       pop;
        logic [7:0] d;
        pop = !nextdata_n && (fifo.size() != 0);
        @(posedge clk);
        #1;
        if (pop) d = fifo.pop_front();
        rx_ready = (fifo.size() != 0);
        rx_data  = rx_ready ? fifo[0] : 8'h00;
        if (evt_make) obs_make++;
        if (evt_break) obs_break++;
        if (evt_make && evt_break) both_evt++;
        if (!nextdata_n) begin
            obs_low++;
            if (prev_low) proto_viol++;
        end
        prev_low = !nextdata_n;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (fifo.size() != 0 && budget < 2000) begin
            step();
            budget++;
        end
        repeat (4) step();
        checks++;
        if (fifo.size() !== 0) begin
            errors++;
            $display("FAIL drain_timeout: fifo left %0d bytes, expected 0", fifo.size());
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        rx_ready = 1'b0; rx_data = 8'h00; rx_overflow = 1'b0;
        fifo.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        obs_make = 0; obs_break = 0; obs_low = 0; proto_viol = 0; both_evt = 0;
        prev_low = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({nextdata_n, key_code, key_ext, key_held, evt_make, evt_break, press_cnt, err}
            !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals: got nd=%b code=%h ext=%b held=%b mk=%b bk=%b cnt=%0d err=%b, expected 1/00/0/0/0/0/0/0",
                     nextdata_n, key_code, key_ext, key_held, evt_make, evt_break, press_cnt, err);
        end
        repeat (5) step();
        checks++;
        if (obs_low !== 0) begin
            errors++;
            $display("FAIL idle_no_pop: got %0d strobes, expected 0", obs_low);
        end
    endtask

    task automatic test_press_release();
        do_reset();
        push(8'h1C);
        drain();
        checks++;
        if (key_held !== 1'b1 || key_code !== 8'h1C || key_ext !== 1'b0) begin
            errors++;
            $display("FAIL pr_press: got held=%b code=%h ext=%b, expected 1/1c/0", key_held, key_code, key_ext);
        end
        push(8'hF0); push(8'h1C);
        drain();
        checks++;
        if (obs_make !== 1 || obs_break !== 1) begin
            errors++;
            $display("FAIL pr_events: got make=%0d break=%0d, expected 1/1", obs_make, obs_break);
        end
        checks++;
        if (key_held !== 1'b0 || key_code !== 8'h1C || press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pr_release: got held=%b code=%h cnt=%0d, expected 0/1c/1", key_held, key_code, press_cnt);
        end
        checks++;
        if (obs_low !== 3 || proto_viol !== 0) begin
            errors++;
            $display("FAIL pr_strobes: got low=%0d back_to_back=%0d, expected 3/0", obs_low, proto_viol);
        end
    endtask

    task automatic test_ext_repeat();
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'h75);
        drain();
        checks++;
        if (obs_make !== 1 || key_ext !== 1'b1 || key_code !== 8'h75 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL ext_make: got make=%0d ext=%b code=%h held=%b, expected 1/1/75/1",
                     obs_make, key_ext, key_code, key_held);
        end
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        checks++;
        if (obs_make !== 1 || obs_break !== 1 || press_cnt !== 8'd1 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL ext_break: got make=%0d break=%0d cnt=%0d held=%b, expected 1/1/1/0",
                     obs_make, obs_break, press_cnt, key_held);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
        drain();
        checks++;
        if (obs_make !== 2 || obs_break !== 1 || press_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ov_events: got make=%0d break=%0d cnt=%0d, expected 2/1/2", obs_make, obs_break, press_cnt);
        end
        checks++;
        if (key_code !== 8'h32 || key_held !== 1'b1 || both_evt !== 0) begin
            errors++;
            $display("FAIL ov_held: got code=%h held=%b both=%0d, expected 32/1/0", key_code, key_held, both_evt);
        end
    endtask

    task automatic test_timeout();
        // Prefix still honoured shortly before the timeout expires.
        do_reset();
        push(8'hE0);
        drain();
        repeat (TB_TIMEOUT - 12) step();
        push(8'h75);
        drain();
        checks++;
        if (key_ext !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL to_early: got ext=%b err=%b, expected 1/0", key_ext, err);
        end
        // Prefix abandoned after the timeout.
        do_reset();
        push(8'hE0);
        drain();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_pending: got err=%b, expected 0", err);
        end
        repeat (TB_TIMEOUT + 8) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL to_err: got err=%b, expected 1", err);
        end
        m_ext_p = 1'b0; m_brk_p = 1'b0;
        push(8'h1C);
        drain();
        checks++;
        if (key_ext !== 1'b0 || key_code !== 8'h1C || obs_make !== 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_after: got ext=%b code=%h make=%0d err=%b, expected 0/1c/1/1",
                     key_ext, key_code, obs_make, err);
        end
    endtask

    task automatic test_nonkey_overflow();
        do_reset();
        push(8'hAA); push(8'hFA);
        drain();
        checks++;
        if (obs_make !== 0 || obs_break !== 0 || press_cnt !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL nk_quiet: got make=%0d break=%0d cnt=%0d err=%b, expected 0/0/0/0",
                     obs_make, obs_break, press_cnt, err);
        end
        rx_overflow = 1'b1;
        step();
        rx_overflow = 1'b0;
        repeat (20) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got err=%b, expected 1", err);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got err=%b, expected 0", err);
        end
        clrn = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] code;
        logic       ext;
        int         kind;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: code = 8'h1C;
                1: code = 8'h32;
                2: code = 8'h75;
                3: code = 8'h23;
                default: code = 8'h6B;
            endcase
            ext  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 4);
            if ((kind == 1 || kind == 2) && m_held && $urandom_range(0, 1) == 1) begin
                code = m_code;
                ext  = m_ext;
            end
            if (kind <= 1) begin
                if (ext) push(8'hE0);
                push(code);
            end else if (kind <= 3) begin
                if (ext) push(8'hE0);
                push(8'hF0);
                push(code);
            end else begin
                case ($urandom_range(0, 4))
                    0: push(8'h00);
                    1: push(8'hAA);
                    2: push(8'hFA);
                    3: push(8'hFE);
                    default: push(8'hFF);
                endcase
            end
            drain();
            repeat ($urandom_range(0, 6)) step();
            checks++;
            if (key_code !== m_code || key_ext !== m_ext || key_held !== m_held || press_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rnd_state[%0d]: got code=%h ext=%b held=%b cnt=%0d, expected %h/%b/%b/%0d",
                         i, key_code, key_ext, key_held, press_cnt, m_code, m_ext, m_held, m_cnt);
            end
            checks++;
            if (obs_make !== m_make || obs_break !== m_break) begin
                errors++;
                $display("FAIL rnd_events[%0d]: got make=%0d break=%0d, expected %0d/%0d",
                         i, obs_make, obs_break, m_make, m_break);
            end
        end
        checks++;
        if (proto_viol !== 0 || both_evt !== 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_protocol: got back_to_back=%0d both=%0d err=%b, expected 0/0/0",
                     proto_viol, both_evt, err);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = 8'h10 + 8'(i / 2);
            if (i % 2 == 1) push(8'hE0);
            push(code);
            if (i % 2 == 1) push(8'hE0);
            push(8'hF0);
            push(code);
            drain();
            if (i == 254) begin
                checks++;
                if (press_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got cnt=%0d, expected 255", press_cnt);
                end
            end
        end
        checks++;
        if (press_cnt !== 8'd0 || obs_make !== 256 || obs_break !== 256 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL wrap_0: got cnt=%0d make=%0d break=%0d held=%b, expected 0/256/256/0",
                     press_cnt, obs_make, obs_break, key_held);
        end
    endtask

    task automatic test_reset_mid_pop();
        int budget;
        do_reset();
        push(8'h1C);
        drain();
        push(8'h32);
        budget = 0;
        while (nextdata_n !== 1'b0 && budget < 20) begin
            step();
            budget++;
        end
        checks++;
        if (nextdata_n !== 1'b0) begin
            errors++;
            $display("FAIL rmp_reach_pop: got nd=%b, expected 0", nextdata_n);
        end
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if ({nextdata_n, key_code, key_ext, key_held, evt_make, evt_break, press_cnt, err}
            !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rmp_async: got nd=%b code=%h held=%b cnt=%0d, expected 1/00/0/0",
                     nextdata_n, key_code, key_held, press_cnt);
        end
        fifo.delete();
        model_clear();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        prev_low = 1'b0;
        obs_make = 0;
        repeat (6) step();
        checks++;
        if (press_cnt !== 8'd0 || obs_make !== 0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL rmp_dropped: got cnt=%0d make=%0d held=%b, expected 0/0/0", press_cnt, obs_make, key_held);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clrn = 1'b0;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        rx_overflow = 1'b0;
        test_reset();
        test_press_release();
        test_ext_repeat();
        test_overlap();
        test_timeout();
        test_nonkey_overflow();
        test_random();
        test_wrap();
        test_reset_mid_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
